// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, S-box, GF(2^8) helpers and FSM state type
package aes_pkg;

    localparam int Nb = 4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
    endfunction

endpackage

// File: rtl/aes_round.sv
// aes_round: one combinational AES round; final_round skips MixColumns
module aes_round
    import aes_pkg::*;
(
    input  logic [0:127] state_i,
    input  logic [0:127] rkey,
    input  logic         final_round,
    output logic [0:127] state_o
);

    logic [0:127] sr;
    logic [0:127] mc;

    // byte index is row + 4*column; SubBytes folded into the ShiftRows gather
    always_comb begin
        sr = '0;
        for (int c = 0; c < Nb; c++)
            for (int r = 0; r < 4; r++)
                sr[8*(r+4*c) +: 8] = SBOX[state_i[8*(r+4*((c+r)%4)) +: 8]];
    end

    for (genvar c = 0; c < Nb; c++) begin : g_mix
        logic [7:0] a0, a1, a2, a3;
        assign {a0, a1, a2, a3} = sr[32*c +: 32];
        assign mc[32*c +: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end

    assign state_o = (final_round ? sr : mc) ^ rkey;

endmodule

// File: rtl/aes_iter_encrypt.sv
// aes_iter_encrypt: iterative AES-128/192/256 encryptor, one round per clock.
// AES_ITER_KEY_REUSE_EN adds key_keep to reuse the previously registered key.
module aes_iter_encrypt
    import aes_pkg::*;
#(
    parameter int KEY_LEN = 128
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef AES_ITER_KEY_REUSE_EN
    input  logic               key_keep,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [0:127]       plain_txt,
    input  logic [0:KEY_LEN-1] key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [0:127]       cipher_txt
);

    localparam int Nk = KEY_LEN / 32;
    localparam int Nr = Nk + 6;
    localparam int NW = Nb * (Nr + 1);
    localparam int RW = $clog2(Nr + 1);

    if (KEY_LEN != 128 && KEY_LEN != 192 && KEY_LEN != 256) begin : g_bad_key_len
        $error("aes_iter_encrypt: KEY_LEN must be 128, 192 or 256");
    end

    // Key_Expansion: full word schedule of a cipher key
    function automatic logic [0:32*NW-1] expand(input logic [0:KEY_LEN-1] k);
        logic [0:32*NW-1] w;
        logic [31:0]      t;
        logic [7:0]       rc;
        w = '0;
        w[0 +: KEY_LEN] = k;
        rc = 8'h01;
        for (int i = Nk; i < NW; i++) begin
            t = w[32*(i-1) +: 32];
            if (i % Nk == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end else if (Nk > 6 && i % Nk == 4) begin
                t = sub_word(t);
            end
            w[32*i +: 32] = w[32*(i-Nk) +: 32] ^ t;
        end
        return w;
    endfunction

    state_t             st_q, st_d;
    logic [0:127]       s_q, s_d, ct_q, ct_d;
    logic [0:KEY_LEN-1] key_q, key_d, key_in;
    logic [RW-1:0]      rnd_q, rnd_d;
    logic               in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic [0:32*NW-1]   w;
    logic [0:127]       rkey, round_out;
    logic               final_round;

`ifdef AES_ITER_KEY_REUSE_EN
    assign key_in = key_keep ? key_q : key;
`else
    assign key_in = key;
`endif

    assign w           = expand(key_q);
    assign rkey        = w[{rnd_q, 7'd0} +: 128];
    assign final_round = rnd_q == RW'(Nr);

    aes_round u_round (
        .state_i     (s_q),
        .rkey        (rkey),
        .final_round (final_round),
        .state_o     (round_out)
    );

    always_comb begin
        st_d        = st_q;
        s_d         = s_q;
        ct_d        = ct_q;
        key_d       = key_q;
        rnd_d       = rnd_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (st_q)
            IDLE: if (in_valid) begin
                key_d      = key_in;
                s_d        = plain_txt ^ key_in[0:127];
                rnd_d      = RW'(1);
                st_d       = RUN;
                in_ready_d = 1'b0;
            end
            RUN: begin
                s_d         = round_out;
                ct_d        = final_round ? round_out : ct_q;
                rnd_d       = final_round ? '0 : rnd_q + 1'b1;
                st_d        = final_round ? DONE : RUN;
                out_valid_d = final_round;
            end
            DONE: if (out_ready) begin
                st_d        = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q        <= IDLE;
            s_q         <= '0;
            ct_q        <= '0;
            key_q       <= '0;
            rnd_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            st_q        <= st_d;
            s_q         <= s_d;
            ct_q        <= ct_d;
            key_q       <= key_d;
            rnd_q       <= rnd_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign cipher_txt = ct_q;

endmodule

// File: tb/tb_aes_iter_encrypt.sv
// tb_aes_iter_encrypt: directed FIPS-197 vectors for aes_iter_encrypt (128/192/256).
module tb_aes_iter_encrypt;

    localparam logic [0:127] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [0:127] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [0:127] C3 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [0:127] C4 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         in_ready, out_valid;
    logic [0:127] plain_txt = '0;
    logic [0:127] key = '0;
    logic [0:127] cipher_txt;
`ifdef AES_ITER_KEY_REUSE_EN
    logic         key_keep = 1'b0;
`endif
    logic         iv_w = 1'b0;
    logic         rdy_w = 1'b1;
    logic [0:191] key_b = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    logic [0:255] key_c = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    logic         ir_b, ov_b, ir_c, ov_c;
    logic [0:127] ct_b, ct_c;
    int           total = 0;
    int           bad = 0;

    always #5 clk = ~clk;

    aes_iter_encrypt u_dut (
        .clk (clk), .rst_n (rst_n),
`ifdef AES_ITER_KEY_REUSE_EN
        .key_keep (key_keep),
`endif
        .in_valid (in_valid), .in_ready (in_ready), .plain_txt (plain_txt), .key (key),
        .out_valid (out_valid), .out_ready (out_ready), .cipher_txt (cipher_txt)
    );

    aes_iter_encrypt #(.KEY_LEN(192)) u_dut192 (
        .clk (clk), .rst_n (rst_n),
`ifdef AES_ITER_KEY_REUSE_EN
        .key_keep (1'b0),
`endif
        .in_valid (iv_w), .in_ready (ir_b), .plain_txt (plain_txt), .key (key_b),
        .out_valid (ov_b), .out_ready (rdy_w), .cipher_txt (ct_b)
    );

    aes_iter_encrypt #(.KEY_LEN(256)) u_dut256 (
        .clk (clk), .rst_n (rst_n),
`ifdef AES_ITER_KEY_REUSE_EN
        .key_keep (1'b0),
`endif
        .in_valid (iv_w), .in_ready (ir_c), .plain_txt (plain_txt), .key (key_c),
        .out_valid (ov_c), .out_ready (rdy_w), .cipher_txt (ct_c)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // noisy drives random in_valid/out_ready/pt/key while the block is running
    task automatic do_block(input string tag, input logic [0:127] k, input logic [0:127] p,
                            input logic [0:127] exp, input int hold, input bit noisy);
        int n;
        key = k;
        plain_txt = p;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            if (noisy) begin
                in_valid  = 1'($urandom);
                out_ready = 1'($urandom);
                plain_txt = {$urandom, $urandom, $urandom, $urandom};
                key       = {$urandom, $urandom, $urandom, $urandom};
            end
            tick;
            n++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check({tag, "_lat"}, 128'(n), 128'd10);
        check({tag, "_ct"}, cipher_txt, exp);
        check({tag, "_ir_done"}, 128'(in_ready), 128'd0);
        for (int i = 0; i < hold; i++) begin
            tick;
            check({tag, "_hold_ct"}, cipher_txt, exp);
            check({tag, "_hold_ov"}, 128'(out_valid), 128'd1);
            check({tag, "_hold_ir"}, 128'(in_ready), 128'd0);
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check({tag, "_ov_after"}, 128'(out_valid), 128'd0);
        check({tag, "_ir_after"}, 128'(in_ready), 128'd1);
        repeat (3) tick;
        check({tag, "_no_2nd"}, 128'(out_valid), 128'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  lb, lc;
        bit  seen;
        logic [0:127] gb, gc;
        repeat (3) tick;
        check("rst_ir", 128'(in_ready), 128'd1);
        check("rst_ov", 128'(out_valid), 128'd0);
        check("rst_ct", cipher_txt, 128'd0);
        check("rst_ir192", 128'(ir_b), 128'd1);
        check("rst_ir256", 128'(ir_c), 128'd1);
        rst_n = 1'b1;
        tick;

        do_block("v029", K1, P1, C1, 0, 1'b0);
        do_block("v031", K2, P2, C2, 5, 1'b0);
        do_block("v032", K1, P1, C1, 0, 1'b1);

        key = K1;
        plain_txt = P1;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (4) tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        check("midrst_ir", 128'(in_ready), 128'd1);
        check("midrst_ov", 128'(out_valid), 128'd0);
        check("midrst_ct", cipher_txt, 128'd0);
        seen = 1'b0;
        repeat (15) begin
            tick;
            seen = seen | out_valid;
        end
        check("midrst_no_ov", 128'(seen), 128'd0);
        do_block("v033", K1, P1, C1, 0, 1'b0);

        plain_txt = P1;
        iv_w = 1'b1;
        tick;
        iv_w = 1'b0;
        lb = 0;
        lc = 0;
        gb = '0;
        gc = '0;
        for (int c = 1; c <= 20; c++) begin
            tick;
            if (ov_b && lb == 0) begin lb = c; gb = ct_b; end
            if (ov_c && lc == 0) begin lc = c; gc = ct_c; end
        end
        check("k192_lat", 128'(lb), 128'd12);
        check("k192_ct", gb, C3);
        check("k256_lat", 128'(lc), 128'd14);
        check("k256_ct", gc, C4);

`ifdef AES_ITER_KEY_REUSE_EN
        do_block("v034a", K1, P1, C1, 0, 1'b0);
        key_keep = 1'b1;
        do_block("v034b", '0, P1, C1, 0, 1'b0);
        key_keep = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_iter_encrypt.md
AES_ITER_ENCRYPT -- requirements
Module: aes_iter_encrypt

Interface
REQ-001 SHALL have parameter KEY_LEN, default 128, AES key length in bits; legal values 128, 192, 256.
REQ-002 SHALL derive localparams Nk = KEY_LEN/32 and Nr = Nk+6, not overridable.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  plain_txt/key valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a new plaintext.
REQ-007 SHALL have port plain_txt  input  [0:127]  plaintext; byte 0 = bits [0:7].
REQ-008 SHALL have port key  input  [0:KEY_LEN-1]  cipher key; byte 0 = bits [0:7].
REQ-009 SHALL have port out_valid  output  1  cipher_txt valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts cipher_txt.
REQ-011 SHALL have port cipher_txt  output  [0:127]  ciphertext, registered.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; one AES round per clk in RUN.
REQ-013 SHALL drive in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-014 Accept edge (IDLE, in_valid & in_ready): SHALL register key, load state <= plain_txt XOR round key 0, round counter <= 1, go RUN.
REQ-015 RUN: SHALL apply SubBytes, ShiftRows, MixColumns, AddRoundKey(round key r) for r = 1..Nr-1; at r = Nr SHALL omit MixColumns.
REQ-016 SHALL move RUN -> DONE on the edge applying round Nr; out_valid first high exactly Nr cycles after the accept edge (10/12/14).
REQ-017 DONE: SHALL hold cipher_txt and out_valid stable until out_ready = 1; on that edge SHALL go IDLE.
REQ-018 in_valid during RUN/DONE SHALL be ignored (no capture, no state change); plain_txt/key changes after accept SHALL not affect the result.
REQ-019 out_ready during IDLE/RUN SHALL be ignored.
REQ-020 Round counter SHALL be ceil(log2(Nr+1)) bits, never exceed Nr, and reset to 0 when not in RUN.
REQ-021 Round keys SHALL be selected from the full expansion of the registered key, indexed by round counter (word range 4r..4r+3).
REQ-022 Illegal KEY_LEN SHALL cause an elaboration-time error.

Reset
REQ-023 On clk edge with rst_n = 0: FSM -> IDLE, in_ready = 1, out_valid = 0, cipher_txt = 0, round counter = 0, state/key registers = 0.
REQ-024 Reset mid-RUN or in DONE SHALL abort the block; no out_valid pulse for it afterwards.

Configuration
REQ-025 Macro AES_ITER_KEY_REUSE_EN: when defined, SHALL add port key_keep  input  1; key_keep = 1 on accept edge retains previously registered key and ignores key input.
REQ-026 Without AES_ITER_KEY_REUSE_EN: key_keep port absent; key SHALL be registered on every accept edge.

Structure
REQ-027 Shared package aes_pkg SHALL hold Nb = 4, S-box table, xtime/GF(2^8) multiply functions, FSM state typedef.
REQ-028 SHALL instantiate exactly one sub-module aes_round (SubBytes/ShiftRows/optional MixColumns/AddRoundKey, combinational, input final_round); existing Key_Expansion SHALL supply the schedule.

Verification
REQ-029 KEY_LEN=128, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid 10 cycles after accept.
REQ-030 KEY_LEN=192, key 000102...1617, same pt -> dda97ca4864cdfe06eaf70a0ec0d7191 after 12 cycles; KEY_LEN=256, key 000102...1e1f -> 8ea2b7ca516745bfeafc49904b496089 after 14 cycles.
REQ-031 KEY_LEN=128, key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, out_ready low 5 cycles after out_valid -> 3925841d02dc09fbdc118597196a0b32 held stable, in_ready 0 throughout, IDLE after handshake.
REQ-032 in_valid toggled with random pt/key during RUN -> result unchanged from REQ-029 vector; no second accept.
REQ-033 rst_n low at round 5 -> next cycle in_ready 1, out_valid 0, cipher_txt 0; fresh REQ-029 vector then passes.
REQ-034 AES_ITER_KEY_REUSE_EN defined: block 1 REQ-029 vector, block 2 key_keep=1 with key=0, same pt -> 69c4e0d86a7b0430d8cdb78070b4c55a.
